// File: rtl/lstm_loader_pkg.sv
// Shared definitions for the LSTM stacked-layer loader: FSM encoding and default sizes.
package lstm_loader_pkg;

    localparam int LSTM_DATA_WIDTH    = 16;
    localparam int LSTM_ADDR_WIDTH    = 7;
    localparam int LSTM_DEPTH         = 128;
    localparam int LSTM_SETTLE_CYCLES = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_CAPTURE = 2'd3
    } loader_state_e;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int settle_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/lstm_loader.sv
// Streams DEPTH data/weight pairs into the stacked LSTM layers, waits for them to
// settle, then captures the final layer's hidden state as the result.
module lstm_loader
    import lstm_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = LSTM_DATA_WIDTH,
    parameter int ADDR_WIDTH    = LSTM_ADDR_WIDTH,
    parameter int DEPTH         = LSTM_DEPTH,
    parameter int SETTLE_CYCLES = LSTM_SETTLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [DATA_WIDTH-1:0] s_weight,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic [ADDR_WIDTH-1:0] gb_data_addr,
    input  logic [DATA_WIDTH-1:0] ht_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  busy
);

    localparam int                  SCW         = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [SCW-1:0]        SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    loader_state_e         state_q, state_d;
    logic                  s_ready_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] weight_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] word_cnt_q;
    logic [SCW-1:0]        settle_cnt_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  result_valid_q;

    logic xfer;
    logic last_word;
    logic settle_done;

    // s_ready_q mirrors state_q == ST_LOAD, so this is exactly the handshake.
    assign xfer        = s_valid && s_ready_q;
    assign last_word   = (word_cnt_q == LAST_WORD);
    assign settle_done = (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);

    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)              state_d = ST_LOAD;
            ST_LOAD:    if (xfer && last_word)  state_d = ST_SETTLE;
            ST_SETTLE:  if (settle_done)        state_d = ST_CAPTURE;
            ST_CAPTURE:                         state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            s_ready_q      <= 1'b0;
            we_q           <= 1'b0;
            data_q         <= '0;
            weight_q       <= '0;
            addr_q         <= '0;
            word_cnt_q     <= '0;
            settle_cnt_q   <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d == ST_LOAD);
            we_q      <= xfer;

            if (xfer) begin
                data_q   <= s_data;
                weight_q <= s_weight;
                addr_q   <= word_cnt_q;
            end

            // Cleared while idle so a load abandoned by reset or finished always restarts at 0.
            if (state_q == ST_IDLE) begin
                word_cnt_q <= '0;
            end else if (xfer) begin
                word_cnt_q <= last_word ? '0 : word_cnt_q + 1'b1;
            end

            if (state_q != ST_SETTLE) begin
                settle_cnt_q <= '0;
            end else if (!settle_done) begin
                settle_cnt_q <= settle_cnt_q + 1'b1;
            end

            result_valid_q <= (state_q == ST_CAPTURE);
            if (state_q == ST_CAPTURE) begin
                result_q <= ht_in;
            end
        end
    end

    assign s_ready      = s_ready_q;
    assign we           = we_q;
    assign data_out     = data_q;
    assign weight_out   = weight_q;
    assign gb_data_addr = addr_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lstm_loader.sv
// Directed bench for lstm_loader: a DEPTH=4 instance for protocol scenarios and a
// DEPTH=128 instance for the full-address-range load.
module tb_lstm_loader;

    logic clk;
    logic rst_n;

    logic        start4, sv4, rdy4, we4, rv4, busy4;
    logic [15:0] sd4, sw4, do4, wo4, ht4, res4;
    logic [6:0]  addr4;

    logic        start8, sv8, rdy8, we8, rv8, busy8;
    logic [15:0] sd8, sw8, do8, wo8, ht8, res8;
    logic [6:0]  addr8;

    int n_vec = 0;
    int n_err = 0;

    lstm_loader #(
        .DATA_WIDTH(16), .ADDR_WIDTH(7), .DEPTH(4), .SETTLE_CYCLES(8)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .s_valid(sv4), .s_ready(rdy4),
        .s_data(sd4), .s_weight(sw4), .we(we4), .data_out(do4), .weight_out(wo4),
        .gb_data_addr(addr4), .ht_in(ht4), .result(res4), .result_valid(rv4), .busy(busy4)
    );

    lstm_loader #(
        .DATA_WIDTH(16), .ADDR_WIDTH(7), .DEPTH(128), .SETTLE_CYCLES(8)
    ) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start(start8), .s_valid(sv8), .s_ready(rdy8),
        .s_data(sd8), .s_weight(sw8), .we(we8), .data_out(do8), .weight_out(wo8),
        .gb_data_addr(addr8), .ht_in(ht8), .result(res8), .result_valid(rv8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle4(output int n);
        n = 0;
        while (busy4 === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_idle8(output int n);
        n = 0;
        while (busy8 === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic start_load4();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start4 = 1'b1; sv4 = 1'b1; sd4 = 16'hFFFF; sw4 = 16'hFFFF; ht4 = 16'hFFFF;
        start8 = 1'b1; sv8 = 1'b1; sd8 = 16'hFFFF; sw8 = 16'hFFFF; ht8 = 16'hFFFF;
        repeat (3) tick();
        n_vec++;
        if ({we4, rdy4, busy4, rv4} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl4: got we/rdy/busy/rv=%b want 0000", {we4, rdy4, busy4, rv4});
        end
        n_vec++;
        if ({do4, wo4, res4, addr4} !== 55'h0) begin
            n_err++;
            $display("FAIL reset_data4: got data=%h weight=%h result=%h addr=%h want all 0",
                     do4, wo4, res4, addr4);
        end
        n_vec++;
        if ({we8, rdy8, busy8, rv8, addr8} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_ctrl128: got we/rdy/busy/rv=%b addr=%h want 0", {we8, rdy8, busy8, rv8}, addr8);
        end
        start4 = 1'b0; sv4 = 1'b0; start8 = 1'b0; sv8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({we4, busy4, rv4, addr4, do4} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_release: got we=%b busy=%b rv=%b addr=%h data=%h want 0",
                     we4, busy4, rv4, addr4, do4);
        end
        tick();
        n_vec++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b rdy=%b want 0 0", busy4, rdy4);
        end
    endtask

    task automatic test_stream();
        int n;
        start_load4();
        n_vec++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b1) begin
            n_err++;
            $display("FAIL stream_enter_load: got rdy=%b busy=%b want 1 1", rdy4, busy4);
        end
        for (int i = 0; i < 4; i++) begin
            sv4 = 1'b1; sd4 = 16'(i + 1); sw4 = 16'(16'h0100 + i);
            tick();
            n_vec++;
            if (we4 !== 1'b1 || addr4 !== 7'(i) || do4 !== 16'(i + 1) || wo4 !== 16'(16'h0100 + i)) begin
                n_err++;
                $display("FAIL stream_write[%0d]: got we=%b addr=%0d data=%h weight=%h want 1 %0d %h %h",
                         i, we4, addr4, do4, wo4, i, 16'(i + 1), 16'(16'h0100 + i));
            end
        end
        sv4 = 1'b0;
        ht4 = 16'h1234;
        n_vec++;
        if (rdy4 !== 1'b0) begin
            n_err++;
            $display("FAIL stream_ready_drop: got rdy=%b want 0", rdy4);
        end
        n = 0;
        while (busy4 === 1'b1 && n < 50) begin
            if (n > 0) begin
                n_vec++;
                if (we4 !== 1'b0) begin
                    n_err++;
                    $display("FAIL stream_settle_we[%0d]: got %b want 0", n, we4);
                end
            end
            n++;
            tick();
        end
        n_vec++;
        if (n != 9) begin
            n_err++;
            $display("FAIL stream_busy_len: got %0d cycles want 9", n);
        end
        n_vec++;
        if (rv4 !== 1'b1 || res4 !== 16'h1234) begin
            n_err++;
            $display("FAIL capture_pulse: got rv=%b result=%h want 1 1234", rv4, res4);
        end
        ht4 = 16'hBEEF;
        tick();
        n_vec++;
        if (rv4 !== 1'b0 || res4 !== 16'h1234) begin
            n_err++;
            $display("FAIL capture_one_cycle: got rv=%b result=%h want 0 1234", rv4, res4);
        end
        tick();
        n_vec++;
        if (res4 !== 16'h1234 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL capture_hold: got result=%h busy=%b want 1234 0", res4, busy4);
        end
    endtask

    task automatic test_stall();
        int       xfers = 0;
        logic [6:0]  exp_addr = 7'd3;
        logic [15:0] exp_data = 16'h0004;
        logic     valid;
        int       n;
        ht4 = 16'h5A5A;
        start_load4();
        for (int k = 0; k < 8; k++) begin
            valid = (k % 2 == 0);
            n_vec++;
            if (rdy4 !== (xfers < 4)) begin
                n_err++;
                $display("FAIL stall_ready[%0d]: got %b want %b", k, rdy4, (xfers < 4));
            end
            sv4 = valid; sd4 = 16'(16'h0020 + k); sw4 = 16'(16'h0040 + k);
            tick();
            if (valid) begin
                exp_addr = 7'(xfers);
                exp_data = 16'(16'h0020 + k);
                xfers++;
            end
            n_vec++;
            if (we4 !== valid || addr4 !== exp_addr || do4 !== exp_data) begin
                n_err++;
                $display("FAIL stall_cycle[%0d]: got we=%b addr=%0d data=%h want %b %0d %h",
                         k, we4, addr4, do4, valid, exp_addr, exp_data);
            end
        end
        sv4 = 1'b0;
        wait_idle4(n);
        n_vec++;
        if (n != 8 || rv4 !== 1'b1 || res4 !== 16'h5A5A) begin
            n_err++;
            $display("FAIL stall_finish: got busy_left=%0d rv=%b result=%h want 8 1 5a5a", n, rv4, res4);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        start4 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            sv4 = 1'b1; sd4 = 16'(16'h0030 + i); sw4 = 16'h0;
            tick();
            n_vec++;
            if (we4 !== 1'b1 || addr4 !== 7'(i) || do4 !== 16'(16'h0030 + i)) begin
                n_err++;
                $display("FAIL start_in_load[%0d]: got we=%b addr=%0d data=%h want 1 %0d %h",
                         i, we4, addr4, do4, i, 16'(16'h0030 + i));
            end
        end
        sv4 = 1'b0;
        n = 0;
        while (busy4 === 1'b1 && n < 50) begin
            if (n == 4) start4 = 1'b0;
            if (n > 0) begin
                n_vec++;
                if (we4 !== 1'b0 || rdy4 !== 1'b0) begin
                    n_err++;
                    $display("FAIL start_in_settle[%0d]: got we=%b rdy=%b want 0 0", n, we4, rdy4);
                end
            end
            n++;
            tick();
        end
        n_vec++;
        if (n != 9) begin
            n_err++;
            $display("FAIL start_busy_len: got %0d cycles want 9", n);
        end
        tick();
        n_vec++;
        if (busy4 !== 1'b0 || addr4 !== 7'd3) begin
            n_err++;
            $display("FAIL start_no_restart: got busy=%b addr=%0d want 0 3", busy4, addr4);
        end
    endtask

    task automatic test_reset_midload();
        int n;
        start_load4();
        for (int i = 0; i < 2; i++) begin
            sv4 = 1'b1; sd4 = 16'(16'h0050 + i); sw4 = 16'h00AA;
            tick();
            n_vec++;
            if (we4 !== 1'b1 || addr4 !== 7'(i)) begin
                n_err++;
                $display("FAIL midload_write[%0d]: got we=%b addr=%0d want 1 %0d", i, we4, addr4, i);
            end
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({we4, rdy4, busy4, rv4, addr4, do4, wo4, res4} !== 59'h0) begin
            n_err++;
            $display("FAIL midload_async_reset: got we=%b rdy=%b busy=%b addr=%0d data=%h weight=%h result=%h want 0",
                     we4, rdy4, busy4, addr4, do4, wo4, res4);
        end
        sv4 = 1'b0;
        repeat (2) tick();
        n_vec++;
        if ({we4, busy4, addr4, do4, res4} !== 41'h0) begin
            n_err++;
            $display("FAIL midload_hold_reset: got we=%b busy=%b addr=%0d data=%h result=%h want 0",
                     we4, busy4, addr4, do4, res4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_load4();
        for (int i = 0; i < 4; i++) begin
            sv4 = 1'b1; sd4 = 16'(16'h0077 + i); sw4 = 16'h0;
            tick();
            n_vec++;
            if (we4 !== 1'b1 || addr4 !== 7'(i) || do4 !== 16'(16'h0077 + i)) begin
                n_err++;
                $display("FAIL restart_write[%0d]: got we=%b addr=%0d data=%h want 1 %0d %h",
                         i, we4, addr4, do4, i, 16'(16'h0077 + i));
            end
        end
        sv4 = 1'b0;
        wait_idle4(n);
        n_vec++;
        if (n != 9) begin
            n_err++;
            $display("FAIL restart_busy_len: got %0d cycles want 9", n);
        end
    endtask

    task automatic test_depth128();
        int n;
        ht8 = 16'hC0DE;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 128; k++) begin
            sv8 = 1'b1; sd8 = 16'(k); sw8 = 16'(16'hFFFF - k);
            tick();
            n_vec++;
            if (we8 !== 1'b1 || addr8 !== 7'(k) || do8 !== 16'(k)) begin
                n_err++;
                $display("FAIL d128_write[%0d]: got we=%b addr=%0d data=%h want 1 %0d %h",
                         k, we8, addr8, do8, k, 16'(k));
            end
        end
        sd8 = 16'hDEAD;
        n_vec++;
        if (rdy8 !== 1'b0 || busy8 !== 1'b1) begin
            n_err++;
            $display("FAIL d128_settle_entry: got rdy=%b busy=%b want 0 1", rdy8, busy8);
        end
        tick();
        n_vec++;
        if (we8 !== 1'b0 || addr8 !== 7'd127 || do8 !== 16'd127) begin
            n_err++;
            $display("FAIL d128_no_wrap: got we=%b addr=%0d data=%h want 0 127 007f", we8, addr8, do8);
        end
        sv8 = 1'b0;
        wait_idle8(n);
        n_vec++;
        if (n != 8 || rv8 !== 1'b1 || res8 !== 16'hC0DE) begin
            n_err++;
            $display("FAIL d128_capture: got busy_left=%0d rv=%b result=%h want 8 1 c0de", n, rv8, res8);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_start_ignored();
        test_reset_midload();
        test_depth128();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
